// File: rtl/i2s_rcvr_frame_sequencer.sv
// I2S receiver frame sequencer: tracks SCK/WS strobes, drives the shift
// enable, pulses L/R capture loads and hands stereo frames downstream.
module i2s_rcvr_frame_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_BITS   = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic sck_rise,
  input  logic ws_sync,
  output logic shift_enable,
  output logic capture_left,
  output logic capture_right,
  output logic frame_valid,
  input  logic frame_ready,
  output logic overflow,
  output logic sync_lost,
  output logic busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_WAIT
  } state_t;

  localparam logic [CNT_BITS-1:0] LP_DW = CNT_BITS'(DATA_WIDTH);

  state_t              r_state, w_state_n;
  logic [CNT_BITS-1:0] r_count, w_count_n;
  logic                r_chan, w_chan_n;
  logic                r_ws_prev, w_ws_prev_n;
  logic                r_ws_seen, w_ws_seen_n;
  logic                r_left_held, w_held_n;
  logic                r_fv, w_fv_n;
  logic                r_cap_l, w_cap_l_n;
  logic                r_cap_r, w_cap_r_n;
  logic                r_ovf, w_ovf_n;
  logic                r_sl, w_sl_n;

  logic                w_ws_change;
  logic                w_pend;
  logic                w_word_done;
  logic [CNT_BITS-1:0] w_cnt_inc;

  assign w_ws_change = sck_rise & r_ws_seen & (ws_sync != r_ws_prev);
  assign w_pend      = r_fv & ~frame_ready;
  assign w_cnt_inc   = r_count + CNT_BITS'(1);
  assign w_word_done = (w_cnt_inc == LP_DW);

  // State and registered pulse outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_chan      <= 1'b0;
      r_ws_prev   <= 1'b0;
      r_ws_seen   <= 1'b0;
      r_left_held <= 1'b0;
      r_fv        <= 1'b0;
      r_cap_l     <= 1'b0;
      r_cap_r     <= 1'b0;
      r_ovf       <= 1'b0;
      r_sl        <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_chan      <= w_chan_n;
      r_ws_prev   <= w_ws_prev_n;
      r_ws_seen   <= w_ws_seen_n;
      r_left_held <= w_held_n;
      r_fv        <= w_fv_n;
      r_cap_l     <= w_cap_l_n;
      r_cap_r     <= w_cap_r_n;
      r_ovf       <= w_ovf_n;
      r_sl        <= w_sl_n;
    end
  end

  // Next-state, word bookkeeping and shift enable
  always_comb begin
    w_state_n    = r_state;
    w_count_n    = r_count;
    w_chan_n     = r_chan;
    w_ws_prev_n  = r_ws_prev;
    w_ws_seen_n  = r_ws_seen;
    w_held_n     = r_left_held;
    w_cap_l_n    = 1'b0;
    w_cap_r_n    = 1'b0;
    w_ovf_n      = 1'b0;
    w_sl_n       = 1'b0;
    shift_enable = 1'b0;

    if (r_cap_r)
      w_fv_n = 1'b1;
    else if (r_fv & frame_ready)
      w_fv_n = 1'b0;
    else
      w_fv_n = r_fv;

    if (!enable) begin
      w_state_n   = S_IDLE;
      w_count_n   = '0;
      w_held_n    = 1'b0;
      w_ws_seen_n = 1'b0;
    end else begin
      if ((r_state != S_IDLE) && sck_rise) begin
        w_ws_prev_n = ws_sync;
        w_ws_seen_n = 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          w_count_n   = '0;
          w_held_n    = 1'b0;
          w_ws_seen_n = 1'b0;
          w_state_n   = S_ARM;
        end
        S_ARM, S_WAIT: begin
          if (w_ws_change) begin
            w_count_n = '0;
            w_chan_n  = ws_sync;
            w_state_n = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sck_rise) begin
            shift_enable = 1'b1;
            w_count_n    = w_cnt_inc;
            if (w_word_done) begin
              w_state_n = S_WAIT;
              if (!r_chan) begin
                if (w_pend) begin
                  w_ovf_n  = 1'b1;
                  w_held_n = 1'b0;
                end else begin
                  w_cap_l_n = 1'b1;
                  w_held_n  = 1'b1;
                end
              end else if (r_left_held) begin
                w_held_n = 1'b0;
                if (w_pend)
                  w_ovf_n = 1'b1;
                else
                  w_cap_r_n = 1'b1;
              end
            end
            if (w_ws_change) begin
              w_count_n = '0;
              w_chan_n  = ws_sync;
              w_state_n = S_SHIFT;
              if (!w_word_done) begin
                w_sl_n   = 1'b1;
                w_held_n = 1'b0;
              end
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  assign capture_left  = r_cap_l;
  assign capture_right = r_cap_r;
  assign frame_valid   = r_fv;
  assign overflow      = r_ovf;
  assign sync_lost     = r_sl;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2s_rcvr_frame_sequencer.sv
// Self-checking bench for i2s_rcvr_frame_sequencer: strobe streams built
// from WS slot layouts, checked against a slot-level reference model.
module tb_i2s_rcvr_frame_sequencer;

  localparam int DW = 16;
  localparam int MAXS = 1024;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic enable = 1'b0;
  logic sck_rise = 1'b0;
  logic ws_sync = 1'b0;
  logic frame_ready = 1'b1;
  logic shift_enable, capture_left, capture_right;
  logic frame_valid, overflow, sync_lost, busy;

  int checks = 0;
  int failures = 0;

  // stream of strobes: ws level and sd bit per sck_rise
  logic ws_a [MAXS];
  logic sd_a [MAXS];
  int   n_str;
  int   slot_start [$];
  logic [DW-1:0] slot_word [$];

  // per strobe {se, cap_l, cap_r, ovf, sync_lost, fv@+2}
  logic [5:0] exp_a [MAXS];
  logic [5:0] obs_a [MAXS];

  logic [DW-1:0] sh, got_l, got_r;
  logic [6:0] outs;

  assign outs = {shift_enable, capture_left, capture_right,
                 frame_valid, overflow, sync_lost, busy};

  i2s_rcvr_frame_sequencer #(.DATA_WIDTH(DW), .CNT_BITS(6)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .sck_rise(sck_rise), .ws_sync(ws_sync),
    .shift_enable(shift_enable),
    .capture_left(capture_left), .capture_right(capture_right),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overflow(overflow), .sync_lost(sync_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stream();
    n_str = 0;
    slot_start.delete();
    slot_word.delete();
    sh = '0;
    got_l = '0;
    got_r = '0;
  endtask

  task automatic add_lead(input logic w, input int n);
    for (int i = 0; i < n; i++) begin
      ws_a[n_str] = w;
      sd_a[n_str] = 1'b0;
      n_str++;
    end
  endtask

  task automatic add_slot(input logic w, input int len,
                          input logic [DW-1:0] word);
    slot_start.push_back(n_str);
    slot_word.push_back(word);
    add_lead(w, len);
  endtask

  // data MSB sits one SCK after the WS transition
  task automatic fin_sd();
    logic [DW-1:0] wd;
    int idx;
    for (int i = 0; i < slot_start.size(); i++) begin
      wd = slot_word[i];
      for (int j = 0; j < DW; j++) begin
        idx = slot_start[i] + 1 + j;
        if (idx < n_str) sd_a[idx] = wd[DW-1-j];
      end
    end
  endtask

  // reference: each WS transition starts a word on the new channel; its
  // bits are the following strobes up to DW of them, ending early (sync
  // lost) if the next transition arrives first; that transition strobe
  // still carries a bit of the old word
  task automatic model();
    int chg [$];
    int c, d, e, lim;
    logic held;
    for (int k = 0; k < n_str; k++) exp_a[k] = '0;
    for (int k = 1; k < n_str; k++)
      if (ws_a[k] != ws_a[k-1]) chg.push_back(k);
    held = 1'b0;
    for (int i = 0; i < chg.size(); i++) begin
      c = chg[i];
      d = (i + 1 < chg.size()) ? chg[i+1] : n_str + DW + 1;
      e = c + DW;
      lim = (d < e) ? d : e;
      for (int k = c + 1; k <= lim && k < n_str; k++) exp_a[k][5] = 1'b1;
      if (e <= d && e < n_str) begin
        if (!ws_a[c]) begin
          exp_a[e][4] = 1'b1;
          held = 1'b1;
        end else if (held) begin
          exp_a[e][3] = 1'b1;
          exp_a[e][0] = 1'b1;
          held = 1'b0;
        end
      end else if (d < e && d < n_str) begin
        exp_a[d][1] = 1'b1;
        held = 1'b0;
      end
    end
  endtask

  // enter at posedge+1; each strobe lasts one clk, spaced 2..gmax clk
  task automatic play(input int gmax);
    int gap;
    for (int k = 0; k < n_str; k++) begin
      ws_sync = ws_a[k];
      sck_rise = 1'b1;
      #1;
      obs_a[k] = '0;
      obs_a[k][5] = shift_enable;
      if (shift_enable) sh = {sh[DW-2:0], sd_a[k]};
      @(posedge clk);
      #1;
      sck_rise = 1'b0;
      obs_a[k][4:1] = {capture_left, capture_right, overflow, sync_lost};
      if (capture_left) got_l = sh;
      if (capture_right) got_r = sh;
      gap = $urandom_range(gmax, 2);
      for (int g = 0; g < gap - 1; g++) begin
        tick();
        if (g == 0) obs_a[k][0] = frame_valid;
      end
    end
  endtask

  task automatic restart();
    sck_rise = 1'b0;
    enable = 1'b0;
    frame_ready = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (outs !== 7'b0) begin
      failures++;
      $display("FAIL reset_outs got %b expected %b", outs, 7'b0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checks++;
    if (outs !== 7'b0) begin
      failures++;
      $display("FAIL idle_outs got %b expected %b", outs, 7'b0);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL arm_busy got %b expected 1", busy);
    end
  endtask

  task automatic test_aligned();
    int nse;
    restart();
    clear_stream();
    add_lead(1'b1, 2);
    add_slot(1'b0, 32, 16'hA5C3);
    add_slot(1'b1, 32, 16'h0F0F);
    add_lead(1'b1, 2);
    fin_sd();
    play(4);
    model();
    nse = 0;
    for (int k = 0; k < n_str; k++) begin
      nse += int'(obs_a[k][5]);
      checks++;
      if (obs_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL aligned strobe %0d got %b expected %b",
                 k, obs_a[k], exp_a[k]);
      end
    end
    checks++;
    if (nse != 32) begin
      failures++;
      $display("FAIL aligned_shifts got %0d expected 32", nse);
    end
    checks++;
    if (got_l !== 16'hA5C3) begin
      failures++;
      $display("FAIL aligned_left got %h expected a5c3", got_l);
    end
    checks++;
    if (got_r !== 16'h0F0F) begin
      failures++;
      $display("FAIL aligned_right got %h expected 0f0f", got_r);
    end
  endtask

  task automatic test_slot16();
    logic [DW-1:0] wl, wr;
    int nsl;
    restart();
    clear_stream();
    add_lead(1'b1, 2);
    for (int i = 0; i < 2; i++) begin
      wl = DW'($urandom);
      wr = DW'($urandom);
      add_slot(1'b0, 16, wl);
      add_slot(1'b1, 16, wr);
    end
    add_lead(1'b0, 2);
    fin_sd();
    play(3);
    model();
    nsl = 0;
    for (int k = 0; k < n_str; k++) begin
      nsl += int'(obs_a[k][1]);
      checks++;
      if (obs_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL slot16 strobe %0d got %b expected %b",
                 k, obs_a[k], exp_a[k]);
      end
    end
    checks++;
    if (nsl != 0) begin
      failures++;
      $display("FAIL slot16_sync_lost got %0d expected 0", nsl);
    end
    checks++;
    if (got_l !== wl || got_r !== wr) begin
      failures++;
      $display("FAIL slot16_data got %h/%h expected %h/%h",
               got_l, got_r, wl, wr);
    end
  endtask

  task automatic test_sync_lost();
    logic [DW-1:0] wl, wr;
    int ncl, ncr, nsl;
    wl = DW'($urandom);
    wr = DW'($urandom);
    restart();
    clear_stream();
    add_lead(1'b1, 2);
    add_slot(1'b0, 10, 16'hFFFF);
    add_slot(1'b1, 32, 16'h1234);
    add_slot(1'b0, 32, wl);
    add_slot(1'b1, 32, wr);
    add_lead(1'b1, 2);
    fin_sd();
    play(4);
    model();
    ncl = 0;
    ncr = 0;
    nsl = 0;
    for (int k = 0; k < n_str; k++) begin
      ncl += int'(obs_a[k][4]);
      ncr += int'(obs_a[k][3]);
      nsl += int'(obs_a[k][1]);
      checks++;
      if (obs_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL sync_lost strobe %0d got %b expected %b",
                 k, obs_a[k], exp_a[k]);
      end
    end
    checks++;
    if (nsl != 1 || ncl != 1 || ncr != 1) begin
      failures++;
      $display("FAIL sync_lost_counts got sl=%0d cl=%0d cr=%0d expected 1/1/1",
               nsl, ncl, ncr);
    end
    checks++;
    if (got_l !== wl || got_r !== wr) begin
      failures++;
      $display("FAIL sync_lost_data got %h/%h expected %h/%h",
               got_l, got_r, wl, wr);
    end
  endtask

  task automatic test_backpressure();
    int ncl, ncr, nov, nsl, s2, first_cr;
    logic held_hi;
    restart();
    frame_ready = 1'b0;
    clear_stream();
    add_lead(1'b1, 2);
    add_slot(1'b0, 32, 16'h1111);
    add_slot(1'b1, 32, 16'h2222);
    s2 = n_str;
    add_slot(1'b0, 32, 16'h3333);
    add_slot(1'b1, 32, 16'h4444);
    add_lead(1'b1, 2);
    fin_sd();
    play(3);
    ncl = 0;
    ncr = 0;
    nov = 0;
    nsl = 0;
    first_cr = -1;
    for (int k = 0; k < n_str; k++) begin
      ncl += int'(obs_a[k][4]);
      ncr += int'(obs_a[k][3]);
      nov += int'(obs_a[k][2]);
      nsl += int'(obs_a[k][1]);
      if (obs_a[k][3] && first_cr < 0) first_cr = k;
    end
    checks++;
    if (ncl != 1 || ncr != 1 || nov != 1 || nsl != 0) begin
      failures++;
      $display("FAIL bp_counts got cl=%0d cr=%0d ov=%0d sl=%0d expected 1/1/1/0",
               ncl, ncr, nov, nsl);
    end
    checks++;
    if (obs_a[s2 + DW][2] !== 1'b1) begin
      failures++;
      $display("FAIL bp_ovf_slot got %b expected 1 at strobe %0d",
               obs_a[s2 + DW][2], s2 + DW);
    end
    held_hi = (first_cr >= 0);
    for (int k = first_cr; k >= 0 && k < n_str; k++)
      if (obs_a[k][0] !== 1'b1) held_hi = 1'b0;
    checks++;
    if (!held_hi) begin
      failures++;
      $display("FAIL bp_valid_held got 0 expected 1 (first cr %0d)", first_cr);
    end
    checks++;
    if (got_l !== 16'h1111 || got_r !== 16'h2222) begin
      failures++;
      $display("FAIL bp_data got %h/%h expected 1111/2222", got_l, got_r);
    end
    frame_ready = 1'b1;
    tick();
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got %b expected 0", frame_valid);
    end
  endtask

  task automatic test_enable_reset();
    logic [DW-1:0] wl, wr;
    restart();
    clear_stream();
    add_lead(1'b1, 2);
    add_slot(1'b0, 32, 16'hBEEF);
    add_lead(1'b1, 8);
    fin_sd();
    play(3);
    model();
    for (int k = 0; k < n_str; k++) begin
      checks++;
      if (obs_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL en_pre strobe %0d got %b expected %b",
                 k, obs_a[k], exp_a[k]);
      end
    end
    enable = 1'b0;
    sck_rise = 1'b1;
    #1;
    checks++;
    if (shift_enable !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_shift got %b expected 0", shift_enable);
    end
    @(posedge clk);
    #1;
    sck_rise = 1'b0;
    checks++;
    if (outs !== 7'b0) begin
      failures++;
      $display("FAIL en_drop_outs got %b expected %b", outs, 7'b0);
    end
    tick();
    enable = 1'b1;
    tick();
    tick();
    wl = DW'($urandom);
    wr = DW'($urandom);
    clear_stream();
    add_lead(1'b0, 2);
    add_slot(1'b1, 32, 16'h5555);
    add_slot(1'b0, 32, wl);
    add_slot(1'b1, 32, wr);
    add_lead(1'b1, 1);
    fin_sd();
    play(3);
    model();
    for (int k = 0; k < n_str; k++) begin
      checks++;
      if (obs_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL en_post strobe %0d got %b expected %b",
                 k, obs_a[k], exp_a[k]);
      end
    end
    checks++;
    if (got_l !== wl || got_r !== wr) begin
      failures++;
      $display("FAIL en_post_data got %h/%h expected %h/%h",
               got_l, got_r, wl, wr);
    end
    clear_stream();
    add_lead(1'b1, 2);
    add_slot(1'b0, 32, 16'h0000);
    add_slot(1'b1, 32, 16'h0000);
    add_slot(1'b0, 7, 16'h0000);
    fin_sd();
    play(3);
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (outs !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid_outs got %b expected %b", outs, 7'b0);
    end
    sck_rise = 1'b1;
    #1;
    checks++;
    if (shift_enable !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_shift got %b expected 0", shift_enable);
    end
    sck_rise = 1'b0;
    tick();
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    tick();
    wl = DW'($urandom);
    wr = DW'($urandom);
    clear_stream();
    add_lead(1'b0, 1);
    add_slot(1'b1, 20, 16'h7777);
    add_slot(1'b0, 24, wl);
    add_slot(1'b1, 18, wr);
    add_lead(1'b1, 1);
    fin_sd();
    play(3);
    model();
    for (int k = 0; k < n_str; k++) begin
      checks++;
      if (obs_a[k] !== exp_a[k]) begin
        failures++;
        $display("FAIL rst_post strobe %0d got %b expected %b",
                 k, obs_a[k], exp_a[k]);
      end
    end
    checks++;
    if (got_l !== wl || got_r !== wr) begin
      failures++;
      $display("FAIL rst_post_data got %h/%h expected %h/%h",
               got_l, got_r, wl, wr);
    end
  endtask

  task automatic test_random();
    logic w;
    int len;
    for (int it = 0; it < 3; it++) begin
      restart();
      clear_stream();
      w = 1'($urandom);
      add_lead(w, $urandom_range(3, 1));
      for (int s = 0; s < 10; s++) begin
        w = ~w;
        len = ($urandom_range(2, 0) == 0) ? 16 : $urandom_range(34, 5);
        add_slot(w, len, DW'($urandom));
      end
      add_lead(~w, 2);
      fin_sd();
      play(4);
      model();
      for (int k = 0; k < n_str; k++) begin
        checks++;
        if (obs_a[k] !== exp_a[k]) begin
          failures++;
          $display("FAIL random%0d strobe %0d got %b expected %b",
                   it, k, obs_a[k], exp_a[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_slot16();
    test_sync_lost();
    test_backpressure();
    test_enable_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_rcvr_frame_sequencer.md
# i2s_rcvr_frame_sequencer

Sequences the I2S receiver datapath. It tracks the synchronized SCK rising-edge strobe and the word-select level, then drives the shift enable for the serial-to-parallel shift register. At each complete word it pulses the left or right capture load, and it presents each assembled stereo frame downstream with a valid/ready handshake. It sits between the SCK/WS edge-detect front end and the sample shift/capture registers.

## Interface
Parameters:
- DATA_WIDTH, 16: bits per channel word captured (MSB first); legal range 4..32.
- CNT_BITS, 6: bit-counter width; must satisfy 2^CNT_BITS > DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge; one clock domain.
- n_rst  in  1  asynchronous active-low reset.
- enable  in  1  receiver enable; low forces IDLE.
- sck_rise  in  1  one-clk strobe per SCK rising edge; already synchronized.
- ws_sync  in  1  synchronized word-select level: 0 = left, 1 = right.
- shift_enable  out  1  shift current SD bit into the shift register this cycle (combinational).
- capture_left  out  1  one-clk pulse: load shift register into the left sample register (registered).
- capture_right  out  1  one-clk pulse: load shift register into the right sample register (registered).
- frame_valid  out  1  left+right pair available.
- frame_ready  in  1  downstream accepts the frame.
- overflow  out  1  one-clk pulse: completed word dropped because a frame was pending.
- sync_lost  out  1  one-clk pulse: WS changed before DATA_WIDTH bits were received.
- busy  out  1  state != IDLE.

## Operation
- ws_prev: ws_sync as sampled at the last sck_rise. ws_seen: set by the first sck_rise after entering ARM. ws_change = sck_rise & ws_seen & (ws_sync != ws_prev).
- IDLE: all counters clear, ws_seen = 0. Go to ARM when enable = 1.
- ARM: on ws_change, set count = 0 and chan = ws_sync, then go to SHIFT. No shift on this edge.
- SHIFT, on sck_rise:
  - If count < DATA_WIDTH: shift_enable = 1 and count++.
  - If count reaches DATA_WIDTH on this edge, the word is complete. Go to WAIT_WS.
  - If ws_change occurs on the same edge, the bit is still shifted (it is the LSB of the old word). Then set count = 0, chan = ws_sync, stay in SHIFT.
  - If ws_change occurs and count+1 < DATA_WIDTH: pulse sync_lost, issue no capture, clear left_held. Restart the word on the new channel with count = 0.
- WAIT_WS: ignore surplus slot bits (no shift). On ws_change, set count = 0 and chan = ws_sync, then go to SHIFT.
- Word complete, chan = 0:
  - If frame_valid & !frame_ready: drop the word, pulse overflow, clear left_held.
  - Otherwise: pulse capture_left, set left_held.
- Word complete, chan = 1:
  - If left_held = 0: discard, no pulses.
  - If a frame is pending and not accepted: pulse overflow, clear left_held.
  - Otherwise: pulse capture_right, clear left_held, set frame_valid the following cycle.
- Handshake: the frame transfers on a clk edge where frame_valid & frame_ready. frame_valid then drops the next cycle. frame_valid is held, unchanged, while frame_ready = 0.
- enable low in any state:
  - Next state is IDLE. count and left_held are cleared. A partial word is discarded with no pulse.
  - A pending frame_valid stays up until accepted.
  - enable low wins over a simultaneous sck_rise.

## Timing
- Reset values: shift_enable = 0, capture_left = 0, capture_right = 0, frame_valid = 0, overflow = 0, sync_lost = 0, busy = 0. State IDLE, count = 0, left_held = 0, ws_seen = 0.
- shift_enable is asserted in the same clk cycle as the qualifying sck_rise.
- Capture pulses, overflow and sync_lost are asserted exactly 1 clk after the sck_rise that completed or broke the word.
- frame_valid rises 1 clk after capture_right, so it is 2 clk after the final sck_rise.
- Minimum sck_rise spacing is 2 clk. Behaviour with back-to-back strobes is undefined.

## Test plan
- Aligned stream, DATA_WIDTH = 16, 32-bit slots, left word 0xA5C3, right word 0x0F0F:
  - 16 shift_enable pulses per slot.
  - capture_left 1 clk after the left slot's 16th bit; capture_right 1 clk after the right slot's 16th bit.
  - frame_valid 2 clk after the final bit; frame accepted with frame_ready = 1.
- 16-bit slots (slot == word): each word's LSB is shifted on the ws_change edge, capture follows 1 clk later, and there is no sync_lost.
- WS toggles after 9 bits of a left word: sync_lost pulses once, no capture_left, the next right word is discarded, and the following L/R pair produces a frame.
- frame_ready held at 0 across two frames: first frame_valid stays high; on the second frame, overflow pulses once, at left-word completion. No capture_left or capture_right pulses occur while the first frame is pending.
- enable dropped mid-word and n_rst asserted mid-word:
  - enable drop: busy = 0 the next clk, no capture.
  - n_rst assertion: all outputs at reset values immediately.
  - After re-enable, the first sck_rise arms only; capture resumes after the next WS transition.
